pwm_serializer: RTL and testbench

PWM_SERIALIZER -- requirements
Module: pwm_serializer

---
 rtl/pwm_serializer.sv | 53 +++++
 tb/tb_pwm_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_serializer.sv
// Free-running PWM generator: prescaler -> 0..99 step counter -> registered compare.
// The output goes high for duty_cycle percent of every 100 * DIV clock period.
module pwm_serializer #(
  parameter int PULSE_FREQ = 1,
  parameter int SYS_FREQ   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] duty_cycle,
  output logic       signal
);

  localparam int DIV_RAW = SYS_FREQ / PULSE_FREQ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [6:0]    STEP_MAX = 7'd99;

  logic [PW-1:0] prescaler;
  logic [6:0]    step;
  logic          tick;

  assign tick = (prescaler == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= '0;
    end else if (tick) begin
      step <= (step == STEP_MAX) ? 7'd0 : step + 7'd1;
    end
  end

  // duty_cycle is not latched per period, so a change lands on the very next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal <= 1'b0;
    end else begin
      signal <= ({1'b0, step} < {1'b0, duty_cycle});
    end
  end

endmodule

// File: tb/tb_pwm_serializer.sv
// Bench for pwm_serializer: stimulus queues expected high/low run lengths,
// a monitor measures runs on the selected DUT output and compares them.
module tb_pwm_serializer;

  logic       clk;
  logic       reset;
  logic [6:0] duty_cycle;
  logic       signal;
  logic       signal10;

  int n_cmp  = 0;
  int n_fail = 0;

  // Segment encoding: bit 15 = level, bits 14:0 = run length in clocks.
  logic [15:0] exp_q[$];

  logic mon_en = 1'b0;
  logic sel    = 1'b0;
  logic active = 1'b0;
  logic cur_lvl;
  logic smp;
  int   run_len;

  pwm_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .duty_cycle (duty_cycle),
    .signal     (signal)
  );

  pwm_serializer #(.PULSE_FREQ(10), .SYS_FREQ(100)) dut10 (
    .clk        (clk),
    .reset      (reset),
    .duty_cycle (duty_cycle),
    .signal     (signal10)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic exp_seg(input logic lvl, input int len);
    exp_q.push_back({lvl, 15'(len)});
  endtask

  task automatic emit(input logic lvl, input int len);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL seg_unexpected: got level %0d len %0d, none expected", lvl, len);
    end else begin
      e = exp_q.pop_front();
      if (e !== {lvl, 15'(len)}) begin
        n_fail++;
        $display("FAIL seg: got level %0d len %0d expected level %0d len %0d",
                 lvl, len, e[15], e[14:0]);
      end
    end
  endtask

  // monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    smp = sel ? signal10 : signal;
    if (mon_en) begin
      if (!active) begin
        active  = 1'b1;
        cur_lvl = smp;
        run_len = 1;
      end else if (smp === cur_lvl) begin
        run_len++;
      end else begin
        emit(cur_lvl, run_len);
        cur_lvl = smp;
        run_len = 1;
      end
    end else if (active) begin
      emit(cur_lvl, run_len);
      active = 1'b0;
    end
  end

  // driver tasks
  task automatic do_reset(input logic [6:0] d);
    @(negedge clk);
    reset      = 1'b1;
    duty_cycle = d;
    @(negedge clk);
    check("reset_signal", int'(signal), 0);
    check("reset_signal10", int'(signal10), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic end_mon();
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset      = 1'b1;
    duty_cycle = 7'd0;
    repeat (3) @(negedge clk);
    check("por_signal", int'(signal), 0);

    // duty 25: rise at edge 1, fall at 2501, rise again at 10001
    do_reset(7'd25);
    exp_seg(1'b1, 2500); exp_seg(1'b0, 7500); exp_seg(1'b1, 1);
    run(10001);
    end_mon();

    // duty 0: never high
    do_reset(7'd0);
    exp_seg(1'b0, 20000);
    run(20000);
    end_mon();

    // duty 99: 9900 high / 100 low
    do_reset(7'd99);
    exp_seg(1'b1, 9900); exp_seg(1'b0, 100);
    run(10000);
    end_mon();

    // duty 100 and 127: constantly high
    do_reset(7'd100);
    exp_seg(1'b1, 3000);
    run(3000);
    end_mon();
    do_reset(7'd127);
    exp_seg(1'b1, 3000);
    run(3000);
    end_mon();

    // asynchronous reset between edges while high, then duty 75
    do_reset(7'd25);
    exp_seg(1'b1, 100);
    run(100);
    end_mon();
    check("pre_reset_high", int'(signal), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_low", int'(signal), 0);
    @(negedge clk);
    duty_cycle = 7'd75;
    reset      = 1'b0;
    mon_en     = 1'b1;
    exp_seg(1'b1, 7500); exp_seg(1'b0, 2500); exp_seg(1'b1, 1);
    run(10001);
    end_mon();

    // duty 75 -> 25 while step = 50: falls at next edge, next period 2500 high
    do_reset(7'd75);
    exp_seg(1'b1, 5000); exp_seg(1'b0, 5000); exp_seg(1'b1, 2500); exp_seg(1'b0, 100);
    run(5000);
    check("step_at_change", int'(dut.step), 50);
    duty_cycle = 7'd25;
    run(7600);
    end_mon();

    // DIV = 10 instance, duty 50: period 1000, counter wraps
    sel = 1'b1;
    do_reset(7'd50);
    exp_seg(1'b1, 500); exp_seg(1'b0, 500); exp_seg(1'b1, 500); exp_seg(1'b0, 500);
    run(999);
    check("div10_pre_max", int'(dut10.prescaler), 9);
    check("div10_step_max", int'(dut10.step), 99);
    run(1);
    check("div10_pre_wrap", int'(dut10.prescaler), 0);
    check("div10_step_wrap", int'(dut10.step), 0);
    run(1000);
    end_mon();
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
